traffic_light_controller: RTL and testbench

Fixed-time traffic light sequencer for a T-junction with four signal heads:
- main road direction 1 (M1)
- main road direction 2 (M2)
- main-road turn lane (MT)
- side road (S)

A six-state Moore FSM with a dwell counter cycles the heads through a safe, non-conflicting sequence. The block is free-running with no sensor inputs, and it sits directly behind the lamp drivers.

---
 rtl/traffic_light_controller.sv | 97 +++++++++
 tb/tb_traffic_light_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time T-junction light sequencer (six-state Moore FSM)
package traffic_light_controller_pkg;
  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } state_t;
endpackage

module traffic_light_controller
  import traffic_light_controller_pkg::*;
#(
  parameter int T_MAIN = 7,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int T_YEL  = 2,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] LAST_MAIN = CNT_W'(T_MAIN - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(T_TURN - 1);
  localparam logic [CNT_W-1:0] LAST_SIDE = CNT_W'(T_SIDE - 1);
  localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  state_t           succ;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] dwell_last;
  logic             legal;
  logic             advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S1;
      count <= '0;
    end else begin
      state <= next_state;
      if (advance) begin
        count <= '0;
      end else begin
        count <= count + CNT_ONE;
      end
    end
  end

  // Unused encodings fall through as illegal and force an immediate return to S1.
  always_comb begin
    legal      = 1'b1;
    succ       = S1;
    dwell_last = '0;
    case (state)
      S1:      begin dwell_last = LAST_MAIN; succ = S2; end
      S2:      begin dwell_last = LAST_YEL;  succ = S3; end
      S3:      begin dwell_last = LAST_TURN; succ = S4; end
      S4:      begin dwell_last = LAST_YEL;  succ = S5; end
      S5:      begin dwell_last = LAST_SIDE; succ = S6; end
      S6:      begin dwell_last = LAST_YEL;  succ = S1; end
      default: legal = 1'b0;
    endcase
    advance    = !legal || (count == dwell_last);
    next_state = advance ? succ : state;
  end

  // Outputs decode the state register only, so rst cannot disturb the lamps between edges.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state)
      S1: begin light_M1 = GREEN;  light_M2 = GREEN;  end
      S2: begin light_M1 = GREEN;  light_M2 = YELLOW; end
      S3: begin light_M1 = GREEN;  light_MT = GREEN;  end
      S4: begin light_M1 = YELLOW; light_MT = YELLOW; end
      S5: light_S = GREEN;
      S6: light_S = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed self-checking bench for traffic_light_controller
module tb_traffic_light_controller;

  logic       clk;
  logic       rst;
  logic [2:0] m1, s, mt, m2;
  logic [2:0] f_m1, f_s, f_mt, f_m2;

  int n_checks = 0;
  int n_pass   = 0;

  traffic_light_controller dut (
    .clk(clk), .rst(rst),
    .light_M1(m1), .light_S(s), .light_MT(mt), .light_M2(m2)
  );

  traffic_light_controller #(
    .T_MAIN(1), .T_TURN(1), .T_SIDE(1), .T_YEL(1), .CNT_W(8)
  ) dut_fast (
    .clk(clk), .rst(rst),
    .light_M1(f_m1), .light_S(f_s), .light_MT(f_mt), .light_M2(f_m2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Hand-written lamp table, packed as {M1, M2, MT, S}.
  function automatic logic [11:0] pat(input int st);
    case (st)
      0:       pat = {3'b001, 3'b001, 3'b100, 3'b100};
      1:       pat = {3'b001, 3'b010, 3'b100, 3'b100};
      2:       pat = {3'b001, 3'b100, 3'b001, 3'b100};
      3:       pat = {3'b010, 3'b100, 3'b010, 3'b100};
      4:       pat = {3'b100, 3'b100, 3'b100, 3'b001};
      default: pat = {3'b100, 3'b100, 3'b100, 3'b010};
    endcase
  endfunction

  // Cycle index within the 21-cycle default period to state index.
  function automatic int st_of(input int c);
    int p;
    p = c % 21;
    if (p < 7)       st_of = 0;
    else if (p < 9)  st_of = 1;
    else if (p < 14) st_of = 2;
    else if (p < 16) st_of = 3;
    else if (p < 19) st_of = 4;
    else             st_of = 5;
  endfunction

  function automatic logic lamp_ok(input logic [2:0] l);
    lamp_ok = (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  task automatic check_invariants(input string tag);
    logic ok;
    ok = lamp_ok(m1) && lamp_ok(m2) && lamp_ok(mt) && lamp_ok(s);
    check({tag, "_onehot"}, {11'd0, ok}, 12'd1);
    ok = (s == 3'b100) || (m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100);
    check({tag, "_side_vs_main"}, {11'd0, ok}, 12'd1);
    ok = (mt == 3'b100) || (m2 == 3'b100);
    check({tag, "_turn_vs_m2"}, {11'd0, ok}, 12'd1);
    ok = (m1 == 3'b100) || (m2 == 3'b100) || (mt == 3'b100) || (s == 3'b100);
    check({tag, "_one_red"}, {11'd0, ok}, 12'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", {m1, m2, mt, s}, pat(0));
    check("reset_hold_fast", {f_m1, f_m2, f_mt, f_s}, pat(0));
    rst = 1'b0;
    #1;
    check("release_no_glitch", {m1, m2, mt, s}, pat(0));

    // Cycle 0 is the sample right after release; runs past 5 periods.
    for (int cyc = 0; cyc <= 122; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check($sformatf("seq_c%0d", cyc), {m1, m2, mt, s}, pat(st_of(cyc)));
      check_invariants($sformatf("inv_c%0d", cyc));
      if (cyc < 12) begin
        check($sformatf("fast_c%0d", cyc), {f_m1, f_m2, f_mt, f_s}, pat(cyc % 6));
      end
    end

    // Now in cycle 17 of a period (S5): one-edge reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_c0", {m1, m2, mt, s}, pat(0));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("midrst_c%0d", c), {m1, m2, mt, s}, pat(st_of(c)));
    end

    // Currently in S3; drive an unused encoding into the state register.
    force dut.state = traffic_light_controller_pkg::state_t'(3'd7);
    #1;
    release dut.state;
    @(negedge clk);
    check("illegal_recover", {m1, m2, mt, s}, pat(0));
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check($sformatf("illegal_c%0d", c), {m1, m2, mt, s}, pat(st_of(c)));
      check_invariants($sformatf("illegal_inv_c%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
